// File: rtl/exec_pkg.sv
// Shared definitions for the execute scheduler: func codes, FU classes,
// per-FU FSM states and default latencies.
package exec_pkg;

    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0001;
    localparam logic [3:0] FN_MUL = 4'b0010;
    localparam logic [3:0] FN_DIV = 4'b0011;
    localparam logic [3:0] FN_LD  = 4'b0100;
    localparam logic [3:0] FN_ST  = 4'b0101;

    localparam int LAT_ADD_DEF = 2;
    localparam int LAT_MUL_DEF = 4;
    localparam int LAT_DIV_DEF = 6;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_MD   = 2'd1,
        CLS_NONE = 2'd2
    } fu_class_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_CDB = 2'd2
    } fu_state_e;

    // Memory ops and unknown codes belong to no execute unit.
    function automatic fu_class_e func_class(input logic [3:0] func);
        case (func)
            FN_ADD, FN_SUB: func_class = CLS_ALU;
            FN_MUL, FN_DIV: func_class = CLS_MD;
            FN_LD, FN_ST:   func_class = CLS_NONE;
            default:        func_class = CLS_NONE;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the first requester strictly after the pointer wins,
// wrapping around, so the last winner gets lowest priority next time.
module rr_arbiter
    import exec_pkg::*;
#(
    parameter int NUM_RS = 4,
    parameter int IDX_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic [NUM_RS-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_RS-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan from ptr+1 upward, keeping only the first hit.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 1; k <= NUM_RS; k++) begin
            cand_s = IDX_W'((int'(ptr_i) + k) % NUM_RS);
            if (!found_s && req_i[cand_s]) begin
                found_s       = 1'b1;
                gnt_o[cand_s] = 1'b1;
                idx_o         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        any_o = found_s;
    end

endmodule

// File: rtl/exec_scheduler.sv
// Issue/complete controller for the ALU and MD execute units: round-robin
// dispatch from the RS, fixed-latency timing and single-CDB write-back.
module exec_scheduler
    import exec_pkg::*;
#(
    parameter int NUM_RS  = 4,
    parameter int ROB_W   = 3,
    parameter int REG_W   = 4,
    parameter int LAT_ADD = LAT_ADD_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF
) (
    input  logic                    clk1,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_RS-1:0]       rs_valid,
    input  logic [NUM_RS*4-1:0]     rs_func,
    input  logic [NUM_RS*ROB_W-1:0] rs_rob,
    input  logic [NUM_RS*REG_W-1:0] rs_rd,
    output logic [NUM_RS-1:0]       rs_grant,
    output logic                    alu_start,
    output logic [3:0]              alu_func,
    output logic                    md_start,
    output logic [3:0]              md_func,
    output logic                    alu_busy,
    output logic                    md_busy,
    output logic                    cdb_valid,
    output logic                    cdb_sel,
    output logic [ROB_W-1:0]        cdb_rob,
    output logic [REG_W-1:0]        cdb_rd
);

    localparam int IDX_W   = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int LAT_MAX = max3(LAT_ADD, LAT_MUL, LAT_DIV);
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    fu_state_e          alu_st_q, alu_st_d, md_st_q, md_st_d;
    logic [CNT_W-1:0]   alu_cnt_q, alu_cnt_d, md_cnt_q, md_cnt_d;
    logic [IDX_W-1:0]   alu_ptr_q, alu_ptr_d, md_ptr_q, md_ptr_d;
    logic [ROB_W-1:0]   alu_rob_q, alu_rob_d, md_rob_q, md_rob_d;
    logic [REG_W-1:0]   alu_rd_q, alu_rd_d, md_rd_q, md_rd_d;
    logic [NUM_RS-1:0]  grant_q, grant_d;
    logic               alu_start_q, alu_start_d, md_start_q, md_start_d;
    logic [3:0]         alu_func_q, alu_func_d, md_func_q, md_func_d;
    logic               alu_busy_q, alu_busy_d, md_busy_q, md_busy_d;
    logic               cdb_valid_q, cdb_valid_d, cdb_sel_q, cdb_sel_d;
    logic [ROB_W-1:0]   cdb_rob_q, cdb_rob_d;
    logic [REG_W-1:0]   cdb_rd_q, cdb_rd_d;

    logic [NUM_RS-1:0]  alu_req_s, md_req_s, alu_gnt_s, md_gnt_s;
    logic [IDX_W-1:0]   alu_idx_s, md_idx_s;
    logic               alu_any_s, md_any_s;
    logic [3:0]         alu_fsel_s, md_fsel_s;
    logic [ROB_W-1:0]   alu_rob_sel_s, md_rob_sel_s;
    logic [REG_W-1:0]   alu_rd_sel_s, md_rd_sel_s;
    logic [CNT_W-1:0]   md_lat_s;
    logic               alu_cdb_req_s, md_cdb_req_s, alu_win_s, md_win_s;

    // Split ready RS entries into per-unit request vectors.
    always_comb begin
        alu_req_s = '0;
        md_req_s  = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            alu_req_s[i] = rs_valid[i] && (func_class(rs_func[4*i +: 4]) == CLS_ALU);
            md_req_s[i]  = rs_valid[i] && (func_class(rs_func[4*i +: 4]) == CLS_MD);
        end
    end

    rr_arbiter #(.NUM_RS(NUM_RS), .IDX_W(IDX_W)) u_alu_arb (
        .req_i (alu_req_s),
        .ptr_i (alu_ptr_q),
        .gnt_o (alu_gnt_s),
        .idx_o (alu_idx_s),
        .any_o (alu_any_s)
    );

    rr_arbiter #(.NUM_RS(NUM_RS), .IDX_W(IDX_W)) u_md_arb (
        .req_i (md_req_s),
        .ptr_i (md_ptr_q),
        .gnt_o (md_gnt_s),
        .idx_o (md_idx_s),
        .any_o (md_any_s)
    );

    // Fields of the selected entries and the CDB winner; a waiting unit beats a fresh finisher.
    always_comb begin
        alu_fsel_s    = rs_func[4*int'(alu_idx_s) +: 4];
        md_fsel_s     = rs_func[4*int'(md_idx_s) +: 4];
        alu_rob_sel_s = rs_rob[ROB_W*int'(alu_idx_s) +: ROB_W];
        md_rob_sel_s  = rs_rob[ROB_W*int'(md_idx_s) +: ROB_W];
        alu_rd_sel_s  = rs_rd[REG_W*int'(alu_idx_s) +: REG_W];
        md_rd_sel_s   = rs_rd[REG_W*int'(md_idx_s) +: REG_W];
        md_lat_s      = (md_fsel_s == FN_DIV) ? CNT_W'(LAT_DIV - 1) : CNT_W'(LAT_MUL - 1);
        alu_cdb_req_s = ((alu_st_q == ST_EXEC) && (alu_cnt_q == '0)) || (alu_st_q == ST_WAIT_CDB);
        md_cdb_req_s  = ((md_st_q == ST_EXEC) && (md_cnt_q == '0)) || (md_st_q == ST_WAIT_CDB);
        md_win_s      = md_cdb_req_s &&
                        !((alu_st_q == ST_WAIT_CDB) && (md_st_q != ST_WAIT_CDB));
        alu_win_s     = alu_cdb_req_s && !md_win_s;
    end

    // Next-state for both unit FSMs, RR pointers and all registered outputs.
    always_comb begin
        alu_st_d    = alu_st_q;
        md_st_d     = md_st_q;
        alu_cnt_d   = alu_cnt_q;
        md_cnt_d    = md_cnt_q;
        alu_ptr_d   = alu_ptr_q;
        md_ptr_d    = md_ptr_q;
        alu_rob_d   = alu_rob_q;
        alu_rd_d    = alu_rd_q;
        md_rob_d    = md_rob_q;
        md_rd_d     = md_rd_q;
        alu_func_d  = alu_func_q;
        md_func_d   = md_func_q;
        grant_d     = '0;
        alu_start_d = 1'b0;
        md_start_d  = 1'b0;
        cdb_valid_d = 1'b0;
        cdb_sel_d   = cdb_sel_q;
        cdb_rob_d   = cdb_rob_q;
        cdb_rd_d    = cdb_rd_q;

        if (flush) begin
            alu_st_d  = ST_IDLE;
            md_st_d   = ST_IDLE;
            alu_cnt_d = '0;
            md_cnt_d  = '0;
        end else begin
            case (alu_st_q)
                ST_IDLE: begin
                    if (alu_any_s) begin
                        grant_d     = grant_d | alu_gnt_s;
                        alu_start_d = 1'b1;
                        alu_func_d  = alu_fsel_s;
                        alu_rob_d   = alu_rob_sel_s;
                        alu_rd_d    = alu_rd_sel_s;
                        alu_ptr_d   = alu_idx_s;
                        alu_cnt_d   = CNT_W'(LAT_ADD - 1);
                        alu_st_d    = ST_EXEC;
                    end else begin
                        alu_st_d = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (alu_cnt_q != '0) begin
                        alu_cnt_d = alu_cnt_q - CNT_W'(1);
                    end else if (alu_win_s) begin
                        alu_st_d = ST_IDLE;
                    end else begin
                        alu_st_d = ST_WAIT_CDB;
                    end
                end
                ST_WAIT_CDB: begin
                    if (alu_win_s) begin
                        alu_st_d = ST_IDLE;
                    end else begin
                        alu_st_d = ST_WAIT_CDB;
                    end
                end
                default: alu_st_d = ST_IDLE;
            endcase

            case (md_st_q)
                ST_IDLE: begin
                    if (md_any_s) begin
                        grant_d    = grant_d | md_gnt_s;
                        md_start_d = 1'b1;
                        md_func_d  = md_fsel_s;
                        md_rob_d   = md_rob_sel_s;
                        md_rd_d    = md_rd_sel_s;
                        md_ptr_d   = md_idx_s;
                        md_cnt_d   = md_lat_s;
                        md_st_d    = ST_EXEC;
                    end else begin
                        md_st_d = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (md_cnt_q != '0) begin
                        md_cnt_d = md_cnt_q - CNT_W'(1);
                    end else if (md_win_s) begin
                        md_st_d = ST_IDLE;
                    end else begin
                        md_st_d = ST_WAIT_CDB;
                    end
                end
                ST_WAIT_CDB: begin
                    if (md_win_s) begin
                        md_st_d = ST_IDLE;
                    end else begin
                        md_st_d = ST_WAIT_CDB;
                    end
                end
                default: md_st_d = ST_IDLE;
            endcase

            if (md_win_s) begin
                cdb_valid_d = 1'b1;
                cdb_sel_d   = 1'b1;
                cdb_rob_d   = md_rob_q;
                cdb_rd_d    = md_rd_q;
            end else if (alu_win_s) begin
                cdb_valid_d = 1'b1;
                cdb_sel_d   = 1'b0;
                cdb_rob_d   = alu_rob_q;
                cdb_rd_d    = alu_rd_q;
            end else begin
                cdb_valid_d = 1'b0;
            end
        end

        alu_busy_d = (alu_st_d != ST_IDLE);
        md_busy_d  = (md_st_d != ST_IDLE);
    end

    // State and output registers; pointers reset to the last entry so entry 0 goes first.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            alu_st_q    <= ST_IDLE;
            md_st_q     <= ST_IDLE;
            alu_cnt_q   <= '0;
            md_cnt_q    <= '0;
            alu_ptr_q   <= IDX_W'(NUM_RS - 1);
            md_ptr_q    <= IDX_W'(NUM_RS - 1);
            alu_rob_q   <= '0;
            alu_rd_q    <= '0;
            md_rob_q    <= '0;
            md_rd_q     <= '0;
            grant_q     <= '0;
            alu_start_q <= 1'b0;
            md_start_q  <= 1'b0;
            alu_func_q  <= 4'b0000;
            md_func_q   <= 4'b0000;
            alu_busy_q  <= 1'b0;
            md_busy_q   <= 1'b0;
            cdb_valid_q <= 1'b0;
            cdb_sel_q   <= 1'b0;
            cdb_rob_q   <= '0;
            cdb_rd_q    <= '0;
        end else begin
            alu_st_q    <= alu_st_d;
            md_st_q     <= md_st_d;
            alu_cnt_q   <= alu_cnt_d;
            md_cnt_q    <= md_cnt_d;
            alu_ptr_q   <= alu_ptr_d;
            md_ptr_q    <= md_ptr_d;
            alu_rob_q   <= alu_rob_d;
            alu_rd_q    <= alu_rd_d;
            md_rob_q    <= md_rob_d;
            md_rd_q     <= md_rd_d;
            grant_q     <= grant_d;
            alu_start_q <= alu_start_d;
            md_start_q  <= md_start_d;
            alu_func_q  <= alu_func_d;
            md_func_q   <= md_func_d;
            alu_busy_q  <= alu_busy_d;
            md_busy_q   <= md_busy_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_sel_q   <= cdb_sel_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_rd_q    <= cdb_rd_d;
        end
    end

    assign rs_grant  = grant_q;
    assign alu_start = alu_start_q;
    assign alu_func  = alu_func_q;
    assign md_start  = md_start_q;
    assign md_func   = md_func_q;
    assign alu_busy  = alu_busy_q;
    assign md_busy   = md_busy_q;
    assign cdb_valid = cdb_valid_q;
    assign cdb_sel   = cdb_sel_q;
    assign cdb_rob   = cdb_rob_q;
    assign cdb_rd    = cdb_rd_q;

endmodule
